// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared type definitions for the LC-3b memory hierarchy.
//   lc3b_word   : 16-bit byte address / data word
//   lc3b_line   : 128-bit cache line
//   arb_state_t : cache_arbiter ownership of the physical-memory port
// GRANT_I / GRANT_D encode the last_grant bit that is used by the optional
// round-robin mode (CACHE_ARBITER_RR_EN).
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arbiter_grant_select.sv
// -----------------------------------------------------------------------------
// arbiter_grant_select
// Combinational grant decision used while the arbiter is idle.
//   i_req      in  I-cache has a pending line read
//   d_req      in  D-cache has a pending line read or writeback
//   last_grant in  side most recently granted (GRANT_I / GRANT_D)
//   next_state out state to enter on the next clock edge
// Macro CACHE_ARBITER_RR_EN: simultaneous requests go to the side that was
// not served last. Without it the D side always wins a tie.
// -----------------------------------------------------------------------------
module arbiter_grant_select
    import lc3b_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last_grant,
    output arb_state_t next_state
);

`ifndef CACHE_ARBITER_RR_EN
    // Fixed priority ignores grant history.
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Choose which requester owns the memory port next
    always_comb begin
        next_state = ARB_IDLE;
        case ({d_req, i_req})
            2'b11: begin
`ifdef CACHE_ARBITER_RR_EN
                if (last_grant == GRANT_D) begin
                    next_state = ARB_SERVE_I;
                end else begin
                    next_state = ARB_SERVE_D;
                end
`else
                next_state = ARB_SERVE_D;
`endif
            end
            2'b10:   next_state = ARB_SERVE_D;
            2'b01:   next_state = ARB_SERVE_I;
            default: next_state = ARB_IDLE;
        endcase
    end

endmodule

// File: rtl/cache_arbiter_checker.sv
// -----------------------------------------------------------------------------
// cache_arbiter_checker
// Simulation-only protocol monitor for the D-cache side of cache_arbiter.
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset (checks suspended while low)
//   d_read  in  D-cache line read request
//   d_write in  D-cache line writeback request
// -----------------------------------------------------------------------------
module cache_arbiter_checker (
    input logic clk,
    input logic reset_n,
    input logic d_read,
    input logic d_write
);

    // A D-side read and writeback can never be requested together
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(d_read && d_write))
                else $error("cache_arbiter: d_read and d_write asserted together");
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Shares the single 128-bit-line physical-memory port between the I-cache miss
// path and the D-cache miss/writeback path, one line transaction at a time.
// Every completion is followed by one idle cycle so a requester that drops its
// request after resp is never granted again by accident.
//
// Ports
//   clk, reset_n                        clock, asynchronous active-low reset
//   i_read, i_address                   I-cache line read request
//   i_rdata, i_resp                     I-cache data / completion pulse
//   d_read, d_write, d_address, d_wdata D-cache read / writeback request
//   d_rdata, d_resp                     D-cache data / completion pulse
//   pmem_read, pmem_write               physical memory strobes
//   pmem_address, pmem_wdata            physical memory address / write data
//   pmem_rdata, pmem_resp               physical memory data / completion
//
// Macro CACHE_ARBITER_RR_EN: round-robin tie break using a last_grant register
// (reset to the I side). Undefined: fixed D-over-I priority.
// -----------------------------------------------------------------------------
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state_r;
    arb_state_t state_next_s;
    arb_state_t grant_next_s;
    logic       last_grant_s;

`ifdef CACHE_ARBITER_RR_EN
    logic last_grant_r;

    // Remember which side was granted most recently, updated on grant entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= GRANT_I;
        end else if ((state_r == ARB_IDLE) && (state_next_s != ARB_IDLE)) begin
            last_grant_r <= (state_next_s == ARB_SERVE_D) ? GRANT_D : GRANT_I;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = GRANT_I;
`endif

    arbiter_grant_select u_grant_select (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_grant (last_grant_s),
        .next_state (grant_next_s)
    );

    cache_arbiter_checker u_checker (
        .clk     (clk),
        .reset_n (reset_n),
        .d_read  (d_read),
        .d_write (d_write)
    );

    // Ownership state register; reset drops any grant immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: grant from idle, release the port on pmem completion
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                state_next_s = grant_next_s;
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (pmem_resp) begin
                    state_next_s = ARB_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // Route the granted requester to pmem and pmem responses back to it only
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_rdata      = '0;
        i_resp       = 1'b0;
        d_rdata      = '0;
        d_resp       = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                // pmem_resp arriving here is stale or spurious and is dropped.
                pmem_read = 1'b0;
            end
            ARB_SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                i_rdata      = pmem_rdata;
                i_resp       = pmem_resp;
            end
            ARB_SERVE_D: begin
                // A simultaneous read+write is illegal; the writeback wins so
                // dirty data is never lost.
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_rdata      = pmem_rdata;
                d_resp       = pmem_resp;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port (pmem, 128-bit line interface) between the I-cache miss path and the D-cache miss/writeback path.
- Sits between the two L1 caches and physical memory (or a future L2).
- Serializes line transactions, one at a time.
- Returns the pmem response only to the granted requester.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits (lc3b_line).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache line address; stable while i_read is high.
- i_rdata  out  LINE_WIDTH  line data to I-cache; valid when i_resp=1.
- i_resp  out  1  single-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line writeback request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  writeback line data.
- d_rdata  out  LINE_WIDTH  line data to D-cache; valid when d_resp=1.
- d_resp  out  1  single-cycle completion pulse to D-cache.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write data.
- pmem_rdata  in  LINE_WIDTH  physical memory read data.
- pmem_resp  in  1  physical memory completion; one-cycle pulse.

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous, active-low.
- FSM states: IDLE, SERVE_I, SERVE_D. The state is registered. Reset forces IDLE.
- IDLE:
  - No pmem strobes; pmem_address=0; pmem_wdata=0.
  - If d_read|d_write, go to SERVE_D next cycle.
  - Else if i_read, go to SERVE_I.
  - Else stay in IDLE.
  - Default priority is fixed, D-side over I-side (see Optional Feature).
- SERVE_I:
  - pmem_read=1, pmem_write=0, pmem_address=i_address, pmem_wdata=0.
  - On pmem_resp: i_resp=1 combinationally in the same cycle, i_rdata=pmem_rdata, next state IDLE.
- SERVE_D:
  - pmem_read=d_read, pmem_write=d_write, pmem_address=d_address, pmem_wdata=d_wdata.
  - On pmem_resp: d_resp=1 in the same cycle, d_rdata=pmem_rdata, next state IDLE.
- Latency:
  - A request seen in IDLE in cycle N drives the pmem strobe from cycle N+1.
  - One mandatory IDLE bubble cycle follows every completion, so a requester deasserting after resp is never re-granted.
  - Minimum turnaround is pmem latency + 2 cycles.
- Outputs to the non-granted side: resp=0 and rdata=0 at all times.
- Reset values: all outputs 0, state IDLE.
- Boundary conditions:
  - pmem_resp while in IDLE: ignored; no resp is generated.
  - d_read and d_write both high: protocol violation. pmem_write wins, pmem_read is forced to 0, and a simulation-only assertion fires.
  - Requester drops its request mid-transaction: the grant is held until pmem_resp. The resp pulse is still issued and is ignored by the requester.
  - Starvation: under fixed priority, continuous D traffic can starve the I-side. This is accepted when the optional feature is off.
  - Reset mid-transaction: state returns to IDLE asynchronously and all strobes drop immediately. Any in-flight pmem response after release is ignored (it arrives in IDLE).
  - Address and wdata pass straight through from the granted requester; the requester holds them stable until resp.

Optional Feature:
- Macro: CACHE_ARBITER_RR_EN.
- Defined:
  - Adds a 1-bit last_grant register (reset 0 = I).
  - On simultaneous requests in IDLE, grant the side NOT served last.
  - last_grant updates on entry to SERVE_I or SERVE_D.
- Undefined: fixed D-over-I priority, no extra register.

Decomposition:
- Add to lc3b_types:
  - lc3b_line typedef (logic [127:0]).
  - arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
- Natural sub-module: arbiter_grant_select. It is combinational and takes request bits plus last_grant, and outputs next_state.
- Everything else stays in a single module: FSM register, output mux, response demux.

Test Plan:
- Single I read: i_read=1, i_address=16'h1230, pmem resp after 3 cycles with rdata=128'hA5..A5.
  - Expect pmem_read from cycle 1, pmem_address=16'h1230.
  - Expect i_resp=1 for exactly one cycle, i_rdata=128'hA5..A5, d_resp=0.
- D writeback: d_write=1, d_address=16'h4000, d_wdata=128'h0123..CDEF.
  - Expect pmem_write=1, pmem_read=0, pmem_wdata matching d_wdata.
  - Expect d_resp pulse, and IDLE for one cycle afterwards.
- Simultaneous i_read and d_read in the same cycle, without RR: D is served first.
  - Then IDLE for one cycle, then I is served.
  - Expect pmem_address sequence d_address, i_address.
- With CACHE_ARBITER_RR_EN, four back-to-back simultaneous-request rounds: grant order is D, I, D, I.
- Reset mid-transaction: assert reset_n=0 during SERVE_D.
  - Expect pmem_write=0 in the same cycle, state IDLE.
  - A late pmem_resp after release produces no d_resp or i_resp.
- Spurious pmem_resp in IDLE: no resp outputs and no state change.
